// File: rtl/ramloader_pkg.sv
// ramloader_pkg
// Shared definitions for the CoreABC RAM APB loader: FSM state encoding,
// RAM geometry (256 words x 16 bits), CSR offsets and CTRL/STATUS bit
// positions. Imported by coreabc_ram_apb_loader and ramloader_clear_seq.
package ramloader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // CSR offset selected by PADDR[0] when PADDR[8]=1
  localparam logic CSR_CTRL = 1'b0;
  localparam logic CSR_FILL = 1'b1;

  // CTRL write bits
  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;

  // STATUS read bits
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_DONE,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/ramloader_clear_seq.sv
// ramloader_clear_seq
// Clear/fill sequencer: holds the FILL pattern, the BUSY and sticky DONE
// flags and the 8-bit address counter that sweeps all 256 RAM words.
// Only built when RAMLOADER_CLEAR_EN is defined.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ctrl_wr         one-cycle CTRL write strobe (only issued while idle)
//   fill_wr         one-cycle FILL write strobe
//   wdata           CSR write data
//   busy, done      STATUS flags
//   last            high during the cycle that writes word 255
//   count           current clear address
//   fill            current fill pattern
`ifdef RAMLOADER_CLEAR_EN
module ramloader_clear_seq
  import ramloader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_wr,
  input  logic              fill_wr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              last,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] fill
);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              start;

  // A start request while already busy is dropped.
  assign start = ctrl_wr && wdata[CTRL_START_BIT] && !busy_q;
  assign last  = busy_q && (count_q == {ADDR_W{1'b1}});

  // Next-state: counter advances every busy cycle and wraps to 0 after 255.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    count_d = count_q;
    fill_d  = fill_q;
    if (fill_wr) fill_d = wdata;
    if (ctrl_wr && wdata[CTRL_CLR_DONE_BIT]) done_d = 1'b0;
    if (start) begin
      busy_d  = 1'b1;
      count_d = '0;
    end else if (busy_q) begin
      count_d = count_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      fill_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;
  assign fill  = fill_q;

endmodule
`endif

// File: rtl/coreabc_ram_apb_loader.sv
// coreabc_ram_apb_loader
// APB3 slave giving a host direct access to the CoreABC 256x16 RAM through
// its synchronous port interface (registered read). Writes complete with no
// wait state, reads with one. Optional clear/fill sequencer enabled by the
// RAMLOADER_CLEAR_EN macro; without it CSR reads return 0 and CSR writes
// are accepted with no effect.
// Ports:
//   PCLK, NSYSRESET          clock (also clocks the RAM), async active-low reset
//   PSEL/PENABLE/PWRITE      APB control
//   PADDR[8:0]               [8]=0 RAM word [7:0]; [8]=1 CSR, [0]: 0=CTRL/STATUS 1=FILL
//   PWDATA/PRDATA            APB data
//   PREADY/PSLVERR           APB completion / error
//   RAM_WEN/RAM_REN          RAM write / read enables
//   RAM_WADDR/RAM_RADDR      RAM addresses
//   RAM_WD/RAM_RD            RAM write data / registered read data
module coreabc_ram_apb_loader
  import ramloader_pkg::*;
(
  input  logic        PCLK,
  input  logic        NSYSRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [8:0]  PADDR,
  input  logic [15:0] PWDATA,
  output logic [15:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        RAM_WEN,
  output logic        RAM_REN,
  output logic [7:0]  RAM_WADDR,
  output logic [7:0]  RAM_RADDR,
  output logic [15:0] RAM_WD,
  input  logic [15:0] RAM_RD
);

  state_t            state_q, state_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              ram_wen_q, ram_wen_d;
  logic              ram_ren_q, ram_ren_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
  logic [DATA_W-1:0] ram_wd_q, ram_wd_d;
  logic [DATA_W-1:0] csr_rdata;
  logic              setup;

  assign setup = PSEL && !PENABLE;

`ifdef RAMLOADER_CLEAR_EN
  logic              ctrl_wr, fill_wr;
  logic              clr_busy, clr_done, clr_last;
  logic [ADDR_W-1:0] clr_count;
  logic [DATA_W-1:0] clr_fill;

  ramloader_clear_seq u_clear_seq (
    .clk     (PCLK),
    .rst_n   (NSYSRESET),
    .ctrl_wr (ctrl_wr),
    .fill_wr (fill_wr),
    .wdata   (PWDATA),
    .busy    (clr_busy),
    .done    (clr_done),
    .last    (clr_last),
    .count   (clr_count),
    .fill    (clr_fill)
  );

  // CSR read mux: STATUS flags or the FILL pattern.
  always_comb begin
    csr_rdata = '0;
    if (PADDR[0] == CSR_FILL) begin
      csr_rdata = clr_fill;
    end else begin
      csr_rdata[STATUS_BUSY_BIT] = clr_busy;
      csr_rdata[STATUS_DONE_BIT] = clr_done;
    end
  end
`else
  assign csr_rdata = '0;
`endif

  // Next-state logic. All APB/RAM outputs are registered: a setup cycle
  // decides what the following access cycle presents.
  always_comb begin
    state_d     = state_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    ram_wen_d   = 1'b0;
    ram_ren_d   = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_raddr_d = ram_raddr_q;
    ram_wd_d    = ram_wd_q;
`ifdef RAMLOADER_CLEAR_EN
    ctrl_wr     = 1'b0;
    fill_wr     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          if (!PADDR[8]) begin
            if (PWRITE) begin
              ram_waddr_d = PADDR[7:0];
              ram_wd_d    = PWDATA;
              ram_wen_d   = 1'b1;
              pready_d    = 1'b1;
              state_d     = ST_WR;
            end else begin
              ram_raddr_d = PADDR[7:0];
              ram_ren_d   = 1'b1;
              state_d     = ST_RD_ISSUE;
            end
          end else begin
            pready_d = 1'b1;
            if (PWRITE) begin
`ifdef RAMLOADER_CLEAR_EN
              ctrl_wr = (PADDR[0] == CSR_CTRL);
              fill_wr = (PADDR[0] == CSR_FILL);
              if (ctrl_wr && PWDATA[CTRL_START_BIT]) state_d = ST_CLEAR;
`endif
            end else begin
              prdata_d = csr_rdata;
            end
          end
        end
      end
      ST_WR:       state_d = ST_IDLE;
      ST_RD_ISSUE: begin
        pready_d = 1'b1;
        state_d  = ST_RD_DONE;
      end
      ST_RD_DONE:  state_d = ST_IDLE;
      ST_CLEAR: begin
        // The sequencer owns the RAM write port; the APB side only answers
        // CSR reads and rejects everything else.
        if (setup) begin
          pready_d = 1'b1;
          if (!PADDR[8] || PWRITE) pslverr_d = 1'b1;
          else                     prdata_d  = csr_rdata;
        end
`ifdef RAMLOADER_CLEAR_EN
        if (clr_last) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q     <= ST_IDLE;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      ram_wd_q    <= '0;
    end else begin
      state_q     <= state_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      ram_wen_q   <= ram_wen_d;
      ram_ren_q   <= ram_ren_d;
      ram_waddr_q <= ram_waddr_d;
      ram_raddr_q <= ram_raddr_d;
      ram_wd_q    <= ram_wd_d;
    end
  end

  // Read data comes straight from the RAM's output register in RD_DONE.
  assign PRDATA  = (state_q == ST_RD_DONE) ? RAM_RD : prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign RAM_REN   = ram_ren_q;
  assign RAM_RADDR = ram_raddr_q;

`ifdef RAMLOADER_CLEAR_EN
  assign RAM_WEN   = ram_wen_q | clr_busy;
  assign RAM_WADDR = clr_busy ? clr_count : ram_waddr_q;
  assign RAM_WD    = clr_busy ? clr_fill  : ram_wd_q;
`else
  assign RAM_WEN   = ram_wen_q;
  assign RAM_WADDR = ram_waddr_q;
  assign RAM_WD    = ram_wd_q;
`endif

endmodule
